// File: rtl/splice_pcj_encoder.sv
// splice_pcj_encoder: two-stage valid/ready pipeline that turns a jump target
// and the PC of the jump into the 26-bit J-type index field. It also flags
// targets that are misaligned or that lie outside the PC's 256 MB region.
// Optional statistics counters are built when SPLICE_PCJ_ENC_STATS_EN is defined.
module splice_pcj_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_target,
  input  logic [31:0]      in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [25:0]      out_ir25_0,
  output logic             out_err_align,
  output logic             out_err_region,
  output logic             out_ok
`ifdef SPLICE_PCJ_ENC_STATS_EN
  ,
  output logic [CNT_W-1:0] jump_count,
  output logic [CNT_W-1:0] err_count
`endif
);

  logic        s1_valid;
  logic [25:0] s1_field;
  logic        s1_align;
  logic        s1_region;
  logic        s2_valid;

  logic        in_xfer;
  logic        s2_xfer;
  logic        s2_load;
  logic        in_align;
  logic        in_region;

  // Only bits [31:28] of the PC select the reachable region.
  logic        pc_low_unused;
  assign pc_low_unused = ^in_pc[27:0];

  assign in_align  = |in_target[1:0];
  assign in_region = (in_target[31:28] != in_pc[31:28]);

  // S2 is free when empty or when its result leaves this cycle; S1 advances
  // exactly when S2 loads, so in_ready chains combinationally from out_ready.
  assign s2_xfer  = s2_valid && out_ready;
  assign s2_load  = s1_valid && (!s2_valid || out_ready);
  assign in_ready = !reset && (!s1_valid || s2_load);
  assign in_xfer  = in_valid && in_ready;

  // No output transfer may complete while reset is held.
  assign out_valid = s2_valid && !reset;

  // Stage 1: capture the accepted request and compute field and error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_field  <= '0;
      s1_align  <= 1'b0;
      s1_region <= 1'b0;
    end else begin
      if (in_xfer) begin
        s1_valid  <= 1'b1;
        s1_field  <= in_target[27:2];
        s1_align  <= in_align;
        s1_region <= in_region;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Stage 2: result registers; data holds whenever nothing new is loaded.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid       <= 1'b0;
      out_ir25_0     <= '0;
      out_err_align  <= 1'b0;
      out_err_region <= 1'b0;
      out_ok         <= 1'b1;
    end else begin
      if (s2_load) begin
        s2_valid       <= 1'b1;
        out_ir25_0     <= s1_field;
        out_err_align  <= s1_align;
        out_err_region <= s1_region;
        out_ok         <= !s1_align && !s1_region;
      end else if (s2_xfer) begin
        s2_valid <= 1'b0;
      end
    end
  end

`ifdef SPLICE_PCJ_ENC_STATS_EN
  // Saturating counts of accepted requests and of requests carrying any error.
  always_ff @(posedge clk) begin
    if (reset) begin
      jump_count <= '0;
      err_count  <= '0;
    end else if (in_xfer) begin
      if (jump_count != {CNT_W{1'b1}})
        jump_count <= jump_count + 1'b1;
      if ((in_align || in_region) && (err_count != {CNT_W{1'b1}}))
        err_count <= err_count + 1'b1;
    end
  end
`else
  logic cnt_w_unused;
  assign cnt_w_unused = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_splice_pcj_encoder.sv
module tb_splice_pcj_encoder;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_target = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [25:0] out_ir25_0;
  logic        out_err_align;
  logic        out_err_region;
  logic        out_ok;
`ifdef SPLICE_PCJ_ENC_STATS_EN
  logic [CNT_W-1:0] jump_count;
  logic [CNT_W-1:0] err_count;
`endif

  splice_pcj_encoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_target(in_target), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ir25_0(out_ir25_0), .out_err_align(out_err_align),
    .out_err_region(out_err_region), .out_ok(out_ok)
`ifdef SPLICE_PCJ_ENC_STATS_EN
    , .jump_count(jump_count), .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [25:0] f;
    logic        a;
    logic        r;
    int          age;
  } ent_t;

  ent_t        q[$];
  logic [25:0] last_f;
  logic        last_a;
  logic        last_r;
  int          n_jump;
  int          n_err;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    last_f = '0;
    last_a = 1'b0;
    last_r = 1'b0;
    n_jump = 0;
    n_err  = 0;
  endtask

  // One clock: drive inputs at negedge, check against the model, then
  // advance the model on the following posedge.
  task automatic step(input bit v, input logic [31:0] t, input logic [31:0] p, input bit rdy);
    bit   exp_ir, exp_ov, ix, ox;
    ent_t e;
    @(negedge clk);
    in_valid = v; in_target = t; in_pc = p; out_ready = rdy;
    #1;
    exp_ir = !(q.size() == 2 && !rdy);
    exp_ov = (q.size() > 0) && (q[0].age >= 1);
    chk("in_ready", {31'b0, in_ready}, {31'b0, exp_ir});
    chk("out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
    if (exp_ov) begin
      chk("out_field", {6'b0, out_ir25_0}, {6'b0, q[0].f});
      chk("out_err_align", {31'b0, out_err_align}, {31'b0, q[0].a});
      chk("out_err_region", {31'b0, out_err_region}, {31'b0, q[0].r});
      chk("out_ok", {31'b0, out_ok}, {31'b0, !(q[0].a || q[0].r)});
    end else begin
      chk("hold_field", {6'b0, out_ir25_0}, {6'b0, last_f});
      chk("hold_ok", {31'b0, out_ok}, {31'b0, !(last_a || last_r)});
    end
`ifdef SPLICE_PCJ_ENC_STATS_EN
    chk("jump_count", {24'b0, jump_count}, (n_jump > CMAX) ? CMAX : n_jump);
    chk("err_count", {24'b0, err_count}, (n_err > CMAX) ? CMAX : n_err);
`endif
    ix = v && exp_ir;
    ox = exp_ov && rdy;
    @(posedge clk);
    if (ox) begin
      last_f = q[0].f; last_a = q[0].a; last_r = q[0].r;
      void'(q.pop_front());
    end
    foreach (q[i]) q[i].age++;
    if (ix) begin
      e.f = 26'((t >> 2) & 32'h03FF_FFFF);
      e.a = (t % 4) != 0;
      e.r = (t >> 28) != (p >> 28);
      e.age = 0;
      q.push_back(e);
      n_jump++;
      if (e.a || e.r) n_err++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    in_target = 32'h1234_5679; in_pc = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    model_clear();
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) step(0, 32'h0, 32'h0, 1);
  endtask

  initial begin
    logic [31:0] t, p;
    model_clear();
    do_reset();
    step(0, 32'h0, 32'h0, 1);

    // nominal: accept, then hold output stalled for a constant check
    step(1, 32'h60C6_01AC, 32'h6000_0000, 0);
    step(0, 32'h0, 32'h0, 0);
    step(0, 32'h0, 32'h0, 0);
    #1;
    chk("nominal_field", {6'b0, out_ir25_0}, 32'h0031_806B);
    chk("nominal_ok", {31'b0, out_ok}, 32'h1);
    drain();

    // alignment error
    step(1, 32'h60C6_01AE, 32'h6000_0000, 0);
    step(0, 32'h0, 32'h0, 0);
    step(0, 32'h0, 32'h0, 0);
    #1;
    chk("align_field", {6'b0, out_ir25_0}, 32'h0031_806B);
    chk("align_flag", {31'b0, out_err_align}, 32'h1);
    chk("align_region", {31'b0, out_err_region}, 32'h0);
    chk("align_ok", {31'b0, out_ok}, 32'h0);
    drain();

    // region error
    step(1, 32'h6000_0010, 32'h7000_0004, 0);
    step(0, 32'h0, 32'h0, 0);
    step(0, 32'h0, 32'h0, 0);
    #1;
    chk("region_field", {6'b0, out_ir25_0}, 32'h0000_0004);
    chk("region_flag", {31'b0, out_err_region}, 32'h1);
    drain();

    // backpressure: three back-to-back requests with the consumer stalled
    step(1, 32'h4, 32'h0, 0);
    step(1, 32'h8, 32'h0, 0);
    step(1, 32'hC, 32'h0, 0);
    step(1, 32'hC, 32'h0, 0);
    #1;
    chk("bp_in_ready_low", {31'b0, in_ready}, 32'h0);
    chk("bp_stable_field", {6'b0, out_ir25_0}, 32'h1);
    step(1, 32'hC, 32'h0, 1);
    drain();

    // streaming with saturation, then reset in mid-stream
    for (int i = 0; i < 300; i++)
      step(1, 32'($urandom), 32'($urandom), 1);
    do_reset();
    step(0, 32'h0, 32'h0, 1);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      p = $urandom;
      t = $urandom;
      if ($urandom_range(0, 2) != 0) t[31:28] = p[31:28];
      if ($urandom_range(0, 2) != 0) t[1:0] = 2'b00;
      step(($urandom_range(0, 3) != 0), t, p, ($urandom_range(0, 2) != 0));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
